// File: rtl/mem_requester.sv
// mem_requester: issues one read or write to an external memory over a
// toggle-encoded handshake. The completion toggle is synchronised, bounded by
// a wait timeout, and reported with a one-cycle done pulse.
module mem_requester #(
   parameter int TIMEOUT = 15
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       op,
   input  logic [7:0] addr,
   input  logic [7:0] wdata,
   output logic       busy,
   output logic       done,
   output logic [7:0] rdata,
   output logic       error,
   output logic       mem_controler,
   output logic       mem_operation,
   output logic [7:0] mem_index,
   output logic [7:0] mem_index_lw,
   output logic [7:0] mem_data_in,
   input  logic       mem_response,
   input  logic [7:0] mem_data_out
);

   typedef enum logic [2:0] {IDLE, SETUP, WAIT, DONE, ERR} state_t;

   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

   state_t     state;
   state_t     state_next;
   logic       s1;
   logic       s2;
   logic       resp_last;
   logic [7:0] counter;
   logic       op_q;
   logic [7:0] addr_q;
   logic [7:0] wdata_q;
   logic       detect;

   // A response is any change of the synchronised toggle since it was last consumed.
   assign detect = (s2 != resp_last);

   // Bus towards memory is driven straight from the latched request so it
   // stays stable from SETUP until the transaction ends.
   assign mem_operation = op_q;
   assign mem_index     = addr_q;
   assign mem_index_lw  = addr_q;
   assign mem_data_in   = wdata_q;

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values of the others.
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state decision; a detected response wins over the timeout.
   always_comb begin
      // NOTE: default first, so no path through the case leaves state_next
      // unassigned and no latch is inferred.
      state_next = state;
      case (state)
         IDLE:  if (start) state_next = SETUP;
         SETUP: state_next = WAIT;
         WAIT: begin
            if (detect)                    state_next = DONE;
            else if (counter == TIMEOUT_C) state_next = ERR;
         end
         DONE:    state_next = IDLE;
         ERR:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Moore outputs: stall while a transaction is open, pulse on completion.
   always_comb begin
      busy = (state != IDLE);
      done = (state == DONE) || (state == ERR);
   end

   // Two-flop synchroniser for the asynchronous response toggle.
   always_ff @(posedge clock or negedge reset) begin
      // NOTE: the synchroniser and handshake flops are reset as well, so a
      // response left pending across reset starts from a known baseline.
      if (!reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= mem_response;
         s2 <= s1;
      end
   end

   // Request latch, handshake toggle, wait counter, read data and error flag.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         resp_last     <= 1'b0;
         counter       <= '0;
         op_q          <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         mem_controler <= 1'b0;
         rdata         <= '0;
         error         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // Tracking here absorbs stray or late toggles between transactions.
               resp_last <= s2;
               if (start) begin
                  op_q    <= op;
                  addr_q  <= addr;
                  wdata_q <= wdata;
                  error   <= 1'b0;
               end
            end
            SETUP: begin
               mem_controler <= ~mem_controler;
               counter       <= '0;
            end
            WAIT: begin
               counter <= counter + 8'd1;
               if (detect) begin
                  resp_last <= s2;
                  if (!op_q) rdata <= mem_data_out;
               end else if (counter == TIMEOUT_C) begin
                  error <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
